// File: rtl/regfile_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_arbiter
//   Shares one 8-entry register file between requester A (core execute) and
//   requester B (debug/loader). Each accepted request is turned into exactly
//   one cycle of get/set/reset enables on the register file. The result goes
//   back on a per-requester valid/ready response channel. After every reset
//   the block clears the whole file once before it accepts any request.
//
//   Optional build macro:
//     REGFILE_ARB_FIXED_PRIORITY_EN  - when defined, A always wins a tie (B can
//                                      starve). When undefined, ties alternate
//                                      round-robin, and A wins the first tie
//                                      after reset.
// -----------------------------------------------------------------------------
module regfile_arbiter #(
    parameter int WORD_SIZE     = 16,
    parameter int REG_ADDR_SIZE = 3,
    parameter int REG_NUM       = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,

    input  logic                     a_req_valid,
    output logic                     a_req_ready,
    input  logic [1:0]               a_req_op,
    input  logic [REG_ADDR_SIZE-1:0] a_req_num1,
    input  logic [REG_ADDR_SIZE-1:0] a_req_num2,
    input  logic [WORD_SIZE-1:0]     a_req_wdata,
    output logic                     a_resp_valid,
    input  logic                     a_resp_ready,
    output logic [WORD_SIZE-1:0]     a_resp_rdata1,
    output logic [WORD_SIZE-1:0]     a_resp_rdata2,

    input  logic                     b_req_valid,
    output logic                     b_req_ready,
    input  logic [1:0]               b_req_op,
    input  logic [REG_ADDR_SIZE-1:0] b_req_num1,
    input  logic [REG_ADDR_SIZE-1:0] b_req_num2,
    input  logic [WORD_SIZE-1:0]     b_req_wdata,
    output logic                     b_resp_valid,
    input  logic                     b_resp_ready,
    output logic [WORD_SIZE-1:0]     b_resp_rdata1,
    output logic [WORD_SIZE-1:0]     b_resp_rdata2,

    output logic [REG_ADDR_SIZE-1:0] rf_num1,
    output logic [REG_ADDR_SIZE-1:0] rf_num2,
    output logic [WORD_SIZE-1:0]     rf_set_val,
    output logic                     rf_get_enable,
    output logic                     rf_set_enable,
    output logic                     rf_reset_enable,
    input  logic [WORD_SIZE-1:0]     rf_out1,
    input  logic [WORD_SIZE-1:0]     rf_out2,

    output logic                     busy
);

    typedef enum logic [1:0] {
        INIT_CLR,
        IDLE,
        RD_CAP,
        RESP
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    // The index width must be able to address every register.
    if (REG_NUM > (1 << REG_ADDR_SIZE)) begin : g_bad_config
        $error("regfile_arbiter: REG_ADDR_SIZE too small for REG_NUM");
    end

    state_t                 state;
    logic                   serve_b;        // requester owning the current op
    logic                   a_resp_valid_q;
    logic                   b_resp_valid_q;
    logic [WORD_SIZE-1:0]   rdata1;
    logic [WORD_SIZE-1:0]   rdata2;

    logic                   a_wins_tie;
    logic                   grant_a;
    logic                   grant_b;
    logic                   any_grant;

    logic [1:0]             sel_op;
    logic [REG_ADDR_SIZE-1:0] sel_num1;
    logic [REG_ADDR_SIZE-1:0] sel_num2;
    logic [WORD_SIZE-1:0]   sel_wdata;

`ifdef REGFILE_ARB_FIXED_PRIORITY_EN
    assign a_wins_tie = 1'b1;
`else
    logic                   last_grant_b;   // 1 when B was granted most recently
    assign a_wins_tie = last_grant_b;
`endif

    // Grants are only given in IDLE, so nothing is accepted while an op is in
    // flight or while the post-reset clear is running.
    assign grant_a   = (state == IDLE) && a_req_valid && (!b_req_valid || a_wins_tie);
    assign grant_b   = (state == IDLE) && b_req_valid && !grant_a;
    assign any_grant = grant_a || grant_b;

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;
    assign busy        = (state != IDLE);

    assign a_resp_valid  = a_resp_valid_q;
    assign b_resp_valid  = b_resp_valid_q;
    assign a_resp_rdata1 = rdata1;
    assign a_resp_rdata2 = rdata2;
    assign b_resp_rdata1 = rdata1;
    assign b_resp_rdata2 = rdata2;

    // Select the fields of whichever request is being granted.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        sel_op    = a_req_op;
        sel_num1  = a_req_num1;
        sel_num2  = a_req_num2;
        sel_wdata = a_req_wdata;
        if (grant_b) begin
            sel_op    = b_req_op;
            sel_num1  = b_req_num1;
            sel_num2  = b_req_num2;
            sel_wdata = b_req_wdata;
        end
    end

    // Drive the register file in the accept cycle only; at most one enable.
    always_comb begin
        rf_num1         = '0;
        rf_num2         = '0;
        rf_set_val      = '0;
        rf_get_enable   = 1'b0;
        rf_set_enable   = 1'b0;
        rf_reset_enable = 1'b0;
        if (any_grant) begin
            case (sel_op)
                OP_READ: begin
                    rf_get_enable = 1'b1;
                    rf_num1       = sel_num1;
                    rf_num2       = sel_num2;
                end
                OP_WRITE: begin
                    rf_set_enable = 1'b1;
                    rf_num1       = sel_num1;
                    rf_set_val    = sel_wdata;
                end
                OP_CLEAR: rf_reset_enable = 1'b1;
                default:  ;
            endcase
        end
        // The post-reset clear is qualified by reset_n, so it does not fire
        // while reset is still held. It fires once, in the cycle after release.
        if ((state == INIT_CLR) && reset_n) begin
            rf_reset_enable = 1'b1;
        end
    end

    // Sequencer: accept, optional read capture, then hold the response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: state is updated with non-blocking assignments, so every
            // register here samples the values from before the edge.
            state          <= INIT_CLR;
            serve_b        <= 1'b0;
            a_resp_valid_q <= 1'b0;
            b_resp_valid_q <= 1'b0;
            rdata1         <= '0;
            rdata2         <= '0;
`ifndef REGFILE_ARB_FIXED_PRIORITY_EN
            last_grant_b   <= 1'b1;
`endif
        end else begin
            case (state)
                INIT_CLR: state <= IDLE;
                IDLE: begin
                    if (any_grant) begin
                        serve_b <= grant_b;
`ifndef REGFILE_ARB_FIXED_PRIORITY_EN
                        last_grant_b <= grant_b;
`endif
                        if (sel_op == OP_READ) begin
                            state <= RD_CAP;
                        end else begin
                            state          <= RESP;
                            rdata1         <= '0;
                            rdata2         <= '0;
                            a_resp_valid_q <= grant_a;
                            b_resp_valid_q <= grant_b;
                        end
                    end
                end
                RD_CAP: begin
                    // The register file presents read data one cycle after get.
                    state          <= RESP;
                    rdata1         <= rf_out1;
                    rdata2         <= rf_out2;
                    a_resp_valid_q <= !serve_b;
                    b_resp_valid_q <= serve_b;
                end
                RESP: begin
                    if ((a_resp_valid_q && a_resp_ready) ||
                        (b_resp_valid_q && b_resp_ready)) begin
                        state          <= IDLE;
                        a_resp_valid_q <= 1'b0;
                        b_resp_valid_q <= 1'b0;
                    end
                end
                default: state <= INIT_CLR;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_arbiter
//   Directed scenarios followed by a randomized phase. A transaction-level
//   reference model predicts the expected values. It holds the expected file
//   contents and the latency, and it applies the arbitration rule; the bench
//   compares the DUT against it every cycle. A simple register file model is
//   attached to the rf_* port. Honours REGFILE_ARB_FIXED_PRIORITY_EN.
// -----------------------------------------------------------------------------
module tb_regfile_arbiter;

    localparam int W  = 16;
    localparam int AW = 3;
    localparam int N  = 8;

    logic          clock = 1'b0;
    logic          reset_n;

    logic          a_req_valid, a_req_ready, a_resp_valid, a_resp_ready;
    logic [1:0]    a_req_op;
    logic [AW-1:0] a_req_num1, a_req_num2;
    logic [W-1:0]  a_req_wdata, a_resp_rdata1, a_resp_rdata2;
    logic          b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
    logic [1:0]    b_req_op;
    logic [AW-1:0] b_req_num1, b_req_num2;
    logic [W-1:0]  b_req_wdata, b_resp_rdata1, b_resp_rdata2;
    logic [AW-1:0] rf_num1, rf_num2;
    logic [W-1:0]  rf_set_val, rf_out1, rf_out2;
    logic          rf_get_enable, rf_set_enable, rf_reset_enable, busy;

    always #5 clock = ~clock;

    regfile_arbiter #(.WORD_SIZE(W), .REG_ADDR_SIZE(AW), .REG_NUM(N)) dut (
        .clock(clock), .reset_n(reset_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_op(a_req_op),
        .a_req_num1(a_req_num1), .a_req_num2(a_req_num2), .a_req_wdata(a_req_wdata),
        .a_resp_valid(a_resp_valid), .a_resp_ready(a_resp_ready),
        .a_resp_rdata1(a_resp_rdata1), .a_resp_rdata2(a_resp_rdata2),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_op(b_req_op),
        .b_req_num1(b_req_num1), .b_req_num2(b_req_num2), .b_req_wdata(b_req_wdata),
        .b_resp_valid(b_resp_valid), .b_resp_ready(b_resp_ready),
        .b_resp_rdata1(b_resp_rdata1), .b_resp_rdata2(b_resp_rdata2),
        .rf_num1(rf_num1), .rf_num2(rf_num2), .rf_set_val(rf_set_val),
        .rf_get_enable(rf_get_enable), .rf_set_enable(rf_set_enable),
        .rf_reset_enable(rf_reset_enable), .rf_out1(rf_out1), .rf_out2(rf_out2),
        .busy(busy)
    );

    // Register file model: outputs are registered one cycle after get.
    logic [W-1:0] rf_mem [N];
    always @(posedge clock) begin
        if (rf_reset_enable) begin
            for (int i = 0; i < N; i++) rf_mem[i] <= '0;
        end else if (rf_set_enable) begin
            rf_mem[rf_num1] <= rf_set_val;
        end
        if (rf_get_enable) begin
            rf_out1 <= rf_mem[rf_num1];
            rf_out2 <= rf_mem[rf_num2];
        end
    end

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] n1;
        logic [AW-1:0] n2;
        logic [W-1:0]  wd;
    } req_t;

    req_t qa[$];
    req_t qb[$];

    // Reference model state (transaction level)
    logic [W-1:0] ref_mem [N];
    bit           m_init, m_resp, m_gap, m_owner_b, m_last_b;
    logic [W-1:0] m_rd1, m_rd2;
    bit           glog[$];          // observed grant order: 0 = A, 1 = B
    bit           obs_ra, obs_rb;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_idle();
        return !m_init && !m_resp && !m_gap;
    endfunction

    function automatic req_t mk(input logic [1:0] op, input logic [AW-1:0] n1,
                                input logic [AW-1:0] n2, input logic [W-1:0] wd);
        req_t r;
        r.op = op; r.n1 = n1; r.n2 = n2; r.wd = wd;
        return r;
    endfunction

    function automatic req_t rand_req();
        int unsigned k = $urandom_range(0, 9);
        logic [1:0] op = (k < 4) ? 2'b00 : (k < 8) ? 2'b01 : (k == 8) ? 2'b10 : 2'b11;
        return mk(op, AW'($urandom_range(0, N-1)), AW'($urandom_range(0, N-1)), W'($urandom));
    endfunction

    task automatic drive();
        if (qa.size() > 0) begin
            a_req_valid = 1'b1; a_req_op = qa[0].op; a_req_num1 = qa[0].n1;
            a_req_num2 = qa[0].n2; a_req_wdata = qa[0].wd;
        end else begin
            a_req_valid = 1'b0; a_req_op = 2'b11; a_req_num1 = '0; a_req_num2 = '0; a_req_wdata = '0;
        end
        if (qb.size() > 0) begin
            b_req_valid = 1'b1; b_req_op = qb[0].op; b_req_num1 = qb[0].n1;
            b_req_num2 = qb[0].n2; b_req_wdata = qb[0].wd;
        end else begin
            b_req_valid = 1'b0; b_req_op = 2'b11; b_req_num1 = '0; b_req_num2 = '0; b_req_wdata = '0;
        end
    endtask

    task automatic push_a(input req_t r); qa.push_back(r); drive(); endtask
    task automatic push_b(input req_t r); qb.push_back(r); drive(); endtask

    // One clock: compare at the falling edge, advance the model at the rising
    // edge, then drive the next inputs 1 ns later.
    task automatic cycle();
        bit a_first, idle, ega, egb, eg, own_b;
        req_t g;
        @(negedge clock);
        if (!reset_n) begin
            m_init = 1; m_resp = 0; m_gap = 0; m_last_b = 1;
        end
`ifdef REGFILE_ARB_FIXED_PRIORITY_EN
        a_first = 1'b1;
`else
        a_first = m_last_b;
`endif
        idle = m_idle();
        ega  = idle && a_req_valid && (!b_req_valid || a_first);
        egb  = idle && b_req_valid && !ega;
        eg   = ega || egb;
        g    = egb ? mk(b_req_op, b_req_num1, b_req_num2, b_req_wdata)
                   : mk(a_req_op, a_req_num1, a_req_num2, a_req_wdata);
        check("a_req_ready", a_req_ready, ega);
        check("b_req_ready", b_req_ready, egb);
        check("busy", busy, !idle);
        check("rf_get_enable", rf_get_enable, eg && g.op == 2'b00);
        check("rf_set_enable", rf_set_enable, eg && g.op == 2'b01);
        check("rf_reset_enable", rf_reset_enable, (m_init && reset_n) || (eg && g.op == 2'b10));
        check("rf_num1", rf_num1, (eg && g.op <= 2'b01) ? g.n1 : '0);
        check("rf_num2", rf_num2, (eg && g.op == 2'b00) ? g.n2 : '0);
        check("rf_set_val", rf_set_val, (eg && g.op == 2'b01) ? g.wd : '0);
        check("a_resp_valid", a_resp_valid, m_resp && !m_owner_b);
        check("b_resp_valid", b_resp_valid, m_resp && m_owner_b);
        if (m_resp) begin
            check("resp_rdata1", m_owner_b ? b_resp_rdata1 : a_resp_rdata1, m_rd1);
            check("resp_rdata2", m_owner_b ? b_resp_rdata2 : a_resp_rdata2, m_rd2);
        end
        obs_ra = a_req_ready;
        obs_rb = b_req_ready;
        @(posedge clock);
        if (!reset_n) begin
            // held in reset
        end else if (m_init) begin
            for (int i = 0; i < N; i++) ref_mem[i] = '0;
            m_init = 0;
        end else if (m_resp) begin
            own_b = m_owner_b;
            if (own_b ? b_resp_ready : a_resp_ready) m_resp = 0;
        end else if (m_gap) begin
            m_gap = 0; m_resp = 1;
        end else if (eg) begin
            m_owner_b = egb; m_last_b = egb;
            m_rd1 = (g.op == 2'b00) ? ref_mem[g.n1] : '0;
            m_rd2 = (g.op == 2'b00) ? ref_mem[g.n2] : '0;
            if (g.op == 2'b01) ref_mem[g.n1] = g.wd;
            if (g.op == 2'b10) for (int i = 0; i < N; i++) ref_mem[i] = '0;
            m_gap  = (g.op == 2'b00);
            m_resp = (g.op != 2'b00);
        end
        if (obs_ra || obs_rb) glog.push_back(obs_rb);
        if (obs_ra && qa.size() > 0) void'(qa.pop_front());
        if (obs_rb && qb.size() > 0) void'(qb.pop_front());
        #1;
        drive();
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        a_resp_ready = 1'b1;
        b_resp_ready = 1'b1;
        while ((qa.size() > 0 || qb.size() > 0 || !m_idle()) && n < max_cycles) begin
            cycle();
            n++;
        end
        if (qa.size() > 0 || qb.size() > 0 || !m_idle()) begin
            vectors++;
            miscompares++;
            $error("FAIL drain_timeout observed=%0d pending expected=0 pending", qa.size() + qb.size());
        end
    endtask

    initial begin
        reset_n      = 1'b1;
        a_resp_ready = 1'b1;
        b_resp_ready = 1'b1;
        drive();
        #1 reset_n = 1'b0;

        // 1: reset state, a single clear pulse after release, then accept
        repeat (3) cycle();
        check("reset_rdata1", a_resp_rdata1, 16'h0000);
        push_a(mk(2'b11, 3'd0, 3'd0, 16'h0));
        reset_n = 1'b1;
        drain(20);

        // 2: write r3 then read r3/r0
        push_a(mk(2'b01, 3'd3, 3'd0, 16'h00A5));
        push_a(mk(2'b00, 3'd3, 3'd0, 16'h0));
        drain(50);

        // 3: both requesters continuously valid, 4 writes each
        push_b(mk(2'b11, 3'd0, 3'd0, 16'h0));   // leaves B as last grant
        drain(20);
        glog.delete();
        for (int i = 0; i < 4; i++) begin
            push_a(mk(2'b01, AW'(i), 3'd0, W'(16'hA000 + i)));
            push_b(mk(2'b01, AW'(i + 4), 3'd0, W'(16'hB000 + i)));
        end
        drain(100);
        check("t3_grant_count", glog.size(), 8);
        for (int i = 0; i < 8 && i < glog.size(); i++) begin
`ifdef REGFILE_ARB_FIXED_PRIORITY_EN
            check($sformatf("t3_grant_%0d", i), glog[i], (i >= 4));
`else
            check($sformatf("t3_grant_%0d", i), glog[i], (i % 2));
`endif
        end

        // 4: A read response stalled while B waits
        push_a(mk(2'b00, 3'd1, 3'd5, 16'h0));
        a_resp_ready = 1'b0;
        cycle();
        push_b(mk(2'b01, 3'd2, 3'd0, 16'h5A5A));
        repeat (7) cycle();
        drain(30);

        // 5: reset during RD_CAP drops the read; the write stands until the clear
        push_a(mk(2'b01, 3'd3, 3'd0, 16'h1234));
        drain(20);
        push_a(mk(2'b00, 3'd3, 3'd3, 16'h0));
        cycle();
        reset_n = 1'b0;
        #2;
        check("t5_a_resp_valid", a_resp_valid, 1'b0);
        check("t5_get_enable", rf_get_enable, 1'b0);
        check("t5_busy", busy, 1'b1);
        repeat (2) cycle();
        reset_n = 1'b1;
        drain(20);
        push_a(mk(2'b00, 3'd3, 3'd0, 16'h0));
        drain(20);
        // reset while a response is being held
        push_a(mk(2'b01, 3'd6, 3'd0, 16'hBEEF));
        a_resp_ready = 1'b0;
        repeat (2) cycle();
        check("t5_resp_held", a_resp_valid, 1'b1);
        reset_n = 1'b0;
        #2;
        check("t5_resp_drop", a_resp_valid, 1'b0);
        check("t5_rdata_drop", a_resp_rdata1, 16'h0000);
        repeat (2) cycle();
        reset_n = 1'b1;
        drain(20);

        // 6: B nop, then B clear
        push_b(mk(2'b11, 3'd5, 3'd6, 16'hFFFF));
        drain(20);
        push_b(mk(2'b01, 3'd7, 3'd0, 16'h7777));
        push_b(mk(2'b10, 3'd0, 3'd0, 16'h0));
        push_b(mk(2'b00, 3'd7, 3'd6, 16'h0));
        drain(40);

        // Randomized traffic with random response back-pressure
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0 && qa.size() < 3) qa.push_back(rand_req());
            if ($urandom_range(0, 3) == 0 && qb.size() < 3) qb.push_back(rand_req());
            a_resp_ready = ($urandom_range(0, 3) != 0);
            b_resp_ready = ($urandom_range(0, 3) != 0);
            drive();
            cycle();
        end
        drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
